sub_seq_ctrl: RTL
=================

Name: sub_seq_ctrl

Overview:
- Multi-cycle sequencer that runs a wide unsigned/two's-complement subtraction A − B one `ancho`-bit slice per clock.
- A single shared slice subtractor is reused every cycle, and the inter-slice carry is held in a register.
- Accepts operands over a valid/ready handshake; returns result plus borrow/zero flags over a second valid/ready handshake.
- Sits between the ALU operation decoder and the narrow subtraction datapath, so wide operands need no wide subtractor.

Parameters:
- ancho, 4, slice width in bits (width of the shared slice subtractor).
- NSLICES, 4, number of slices per operation; total operand width W = ancho*NSLICES (default 16).

Ports:
- clk  input  1  clock, rising-edge.
- rst_n  input  1  reset; asynchronous assert, active-low.
- in_valid  input  1  operands present on op_a/op_b.
- in_ready  output  1  block can accept an operation (high only in IDLE).
- op_a  input  W  minuend.
- op_b  input  W  subtrahend.
- out_valid  output  1  result/flags valid.
- out_ready  input  1  consumer accepts result.
- result  output  W  (op_a − op_b) mod 2^W.
- borrow  output  1  1 when op_a < op_b, unsigned.
- zero  output  1  1 when result == 0.
- busy  output  1  high in RUN.

Behaviour:
- Reset (rst_n=0, async): state=IDLE; in_ready=1; out_valid=0; busy=0; result=0; borrow=0; zero=0; slice index=0; carry register=1.
- States: IDLE, RUN, DONE.
- IDLE:
  - in_ready=1.
  - On in_valid&in_ready: latch op_a/op_b into internal registers; slice index=0; carry=1; go to RUN.
  - Operand changes after the accept cycle have no effect.
- RUN: each cycle, for slice k = index:
  - s = a[k] + ~b[k] + carry, computed at ancho+1 bits.
  - result[k*ancho +: ancho] = s[ancho-1:0].
  - carry = s[ancho].
  - index increments.
  - After slice NSLICES−1: go to DONE with borrow = ~final carry.
  - Latency from accept to out_valid is exactly NSLICES+1 cycles (accept edge, then NSLICES RUN cycles).
- DONE:
  - out_valid=1. result and flags are stable and held while out_ready=0.
  - On out_valid&out_ready: out_valid drops next cycle; go to IDLE.
  - in_ready stays 0 in DONE, so there is no same-cycle re-accept. Minimum issue interval is NSLICES+2 cycles.
- zero: registered with the final slice, as NOR of the full result.
- Result bits of slices not yet processed hold their values from the previous operation until overwritten. Consumers sample only when out_valid=1.
- Reset mid-RUN or mid-DONE: the operation is abandoned, all outputs go to reset values immediately, and no partial result is ever flagged valid.
- in_valid asserted in RUN/DONE is ignored (in_ready=0). The requester holds it.
- NSLICES=1 is legal: a single RUN cycle.
- Wrap-around: 0 − 1 gives result all-ones, borrow=1.

Optional Feature:
- Macro: SUB_SEQ_OVF_EN.
- Defined: adds output port `ovf` (1 bit, reset 0), updated with the final slice.
  - ovf = signed two's-complement overflow = (a[W−1] != b[W−1]) && (result[W−1] != a[W−1]).
  - Held in DONE like the other flags.
- Undefined: no `ovf` port or logic. All other behaviour is identical.

Test Plan (defaults ancho=4, NSLICES=4, W=16):
- Basic: op_a=16'h1234, op_b=16'h0111, in_valid pulse, out_ready=1 → out_valid exactly 5 cycles after accept; result=16'h1123, borrow=0, zero=0; in_ready returns 1 one cycle after the handshake.
- Borrow chain across every slice: op_a=16'h0000, op_b=16'h0001 → result=16'hFFFF, borrow=1, zero=0. With SUB_SEQ_OVF_EN: ovf=0.
- Zero and backpressure: op_a=op_b=16'hA5A5, out_ready held 0 for 10 cycles → result=0, zero=1, borrow=0; outputs stable and in_ready=0 throughout; completes one cycle after out_ready=1.
- Signed overflow (SUB_SEQ_OVF_EN): op_a=16'h8000, op_b=16'h0001 → result=16'h7FFF, ovf=1, borrow=0. Also op_a=16'h7FFF, op_b=16'hFFFF → result=16'h8000, ovf=1, borrow=1.
- Reset mid-operation: accept 16'h5555−16'h1111, assert rst_n=0 during the 2nd RUN cycle → out_valid=0, in_ready=1, result=0, borrow=0, zero=0 immediately. Release, then issue 16'h0010−16'h0001 → result=16'h000F with the full 5-cycle latency.
- Back-to-back with ignored request: hold in_valid=1 continuously with new operands changing during RUN → the second op is accepted only on the first IDLE cycle after the first result handshake; both results correct for the operands present at their respective accept edges.

Source files
------------

// File: rtl/sub_seq_ctrl.sv
// sub_seq_ctrl: computes a wide A - B by reusing one ancho-bit slice subtractor,
// one slice per clock, with the inter-slice carry held in a register.
//
// Ports:
//   clk, rst_n           clock (rising edge), async active-low reset
//   in_valid / in_ready  operand handshake; in_ready is high only in IDLE
//   op_a, op_b           W-bit minuend / subtrahend, latched on accept
//   out_valid/out_ready  result handshake; result and flags held in DONE
//   result               (op_a - op_b) mod 2^W
//   borrow               op_a < op_b (unsigned)
//   zero                 result == 0
//   busy                 high while slices are being processed
//   ovf                  signed overflow; present only with SUB_SEQ_OVF_EN
//
// Build option: define SUB_SEQ_OVF_EN to add the ovf output.

module sub_seq_ctrl #(
    parameter int ancho   = 4,
    parameter int NSLICES = 4,
    localparam int W      = ancho * NSLICES,
    localparam int IW     = (NSLICES > 1) ? $clog2(NSLICES) : 1
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [W-1:0] op_a,
    input  logic [W-1:0] op_b,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [W-1:0] result,
    output logic         borrow,
    output logic         zero,
`ifdef SUB_SEQ_OVF_EN
    output logic         ovf,
`endif
    output logic         busy
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_e;

    state_e        state_q;
    logic [W-1:0]  a_q;
    logic [W-1:0]  b_q;
    logic [IW-1:0] idx_q;
    logic          carry_q;

    logic [ancho-1:0] a_sl;
    logic [ancho-1:0] b_sl;
    logic [ancho:0]   sum;
    logic [W-1:0]     res_d;
    logic             last_d;
    logic             zero_d;
    logic             borrow_d;
`ifdef SUB_SEQ_OVF_EN
    logic             ovf_d;
`endif

    // Shared slice subtractor: a + ~b + carry at ancho+1 bits.
    // res_d is the full result with the current slice merged in, so the
    // zero flag can be taken over the whole word on the final slice.
    always_comb begin
        a_sl     = a_q[int'(idx_q) * ancho +: ancho];
        b_sl     = b_q[int'(idx_q) * ancho +: ancho];
        sum      = {1'b0, a_sl} + {1'b0, ~b_sl}
                 + {{ancho{1'b0}}, carry_q};
        res_d    = result;
        res_d[int'(idx_q) * ancho +: ancho] = sum[ancho-1:0];
        last_d   = (idx_q == IW'(NSLICES - 1));
        zero_d   = ~|res_d;
        borrow_d = ~sum[ancho];
`ifdef SUB_SEQ_OVF_EN
        // On the last slice, the slice MSBs are the word sign bits.
        ovf_d    = (a_sl[ancho-1] != b_sl[ancho-1])
                && (sum[ancho-1] != a_sl[ancho-1]);
`endif
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            a_q       <= '0;
            b_q       <= '0;
            idx_q     <= '0;
            carry_q   <= 1'b1;
            in_ready  <= 1'b1;
            out_valid <= 1'b0;
            busy      <= 1'b0;
            result    <= '0;
            borrow    <= 1'b0;
            zero      <= 1'b0;
`ifdef SUB_SEQ_OVF_EN
            ovf       <= 1'b0;
`endif
        end else begin
            unique case (state_q)
                IDLE: begin
                    if (in_valid) begin
                        a_q      <= op_a;
                        b_q      <= op_b;
                        idx_q    <= '0;
                        carry_q  <= 1'b1;
                        in_ready <= 1'b0;
                        busy     <= 1'b1;
                        state_q  <= RUN;
                    end
                end
                RUN: begin
                    result  <= res_d;
                    carry_q <= sum[ancho];
                    if (last_d) begin
                        idx_q     <= '0;
                        borrow    <= borrow_d;
                        zero      <= zero_d;
`ifdef SUB_SEQ_OVF_EN
                        ovf       <= ovf_d;
`endif
                        busy      <= 1'b0;
                        out_valid <= 1'b1;
                        state_q   <= DONE;
                    end else begin
                        idx_q <= idx_q + IW'(1);
                    end
                end
                DONE: begin
                    if (out_ready) begin
                        out_valid <= 1'b0;
                        in_ready  <= 1'b1;
                        state_q   <= IDLE;
                    end
                end
                default: begin
                    out_valid <= 1'b0;
                    busy      <= 1'b0;
                    in_ready  <= 1'b1;
                    state_q   <= IDLE;
                end
            endcase
        end
    end

endmodule
